ps2_mouse_rx: RTL and testbench

- Receive-only PS/2 mouse front end. It deserialises device-to-host frames, assembles standard 3-byte stream-mode packets, and integrates the motion into clamped absolute cursor coordinates plus click ticks.
- It replaces the button-driven cursor path: its outputs drive the top RTL's cursor inputs and button-click input directly.
- Sending the stream-enable command (0xF4) is handled by a separate host-to-device block and is out of scope here.
- Open-drain/tristate handling lives at the top level; this block only samples the lines.

---
 rtl/ps2_mouse_rx_if.sv | 25 ++
 rtl/ps2_mouse_rx.sv | 207 ++++++++++++++++++++
 tb/tb_ps2_mouse_rx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ps2_mouse_rx_if.sv
// PS/2 mouse receiver bus: the raw PS/2 lines in, cursor position, button state and status pulses out.
// master = the PS/2 device side (it drives the lines), slave = ps2_mouse_rx.
interface ps2_mouse_rx_if #(
  parameter int OUTWIDTH = 8
);
  logic                ps2_clk;
  logic                ps2_data;
  logic [OUTWIDTH-1:0] xcursor;
  logic [OUTWIDTH-1:0] ycursor;
  logic                left_click;
  logic                right_click;
  logic                left_level;
  logic                pkt_valid;
  logic                frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  xcursor, ycursor, left_click, right_click, left_level, pkt_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output xcursor, ycursor, left_click, right_click, left_level, pkt_valid, frame_err
  );
endinterface

// File: rtl/ps2_mouse_rx.sv
// Receive-only PS/2 mouse front end: frame deserialiser, 3-byte packet assembler,
// and integrator that turns relative motion into a clamped absolute cursor position plus click pulses.
//
// state   | meaning
// S_IDLE  | waiting for a start bit (a falling clock edge with data low)
// S_SHIFT | collecting data bits 1-8, the parity bit and the stop bit
// S_DONE  | frame finished; byte_valid or byte_err is high in this cycle
module ps2_mouse_rx #(
  parameter int OUTWIDTH    = 8,
  parameter int MINVAL      = 0,
  parameter int MAXVAL      = 255,
  parameter int INIT_X      = 128,
  parameter int INIT_Y      = 128,
  parameter int SHIFT       = 0,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 80000
) (
  input logic           clk,
  input logic           rst,
  ps2_mouse_rx_if.slave bus
);
  // The sum needs at least 10 bits so that a full -256..+255 delta fits alongside the cursor value.
  localparam int SW = (OUTWIDTH + 2 > 10) ? OUTWIDTH + 2 : 10;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic signed [SW-1:0] MIN_S = SW'(MINVAL);
  localparam logic signed [SW-1:0] MAX_S = SW'(MAXVAL);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt, fall;
  logic [FW-1:0] filt_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      clk_s1 <= bus.ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= bus.ps2_data;
      dat_s2 <= dat_s1;
      fall   <= 1'b0;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_cnt <= '0;
        clk_filt <= clk_s2;
        fall     <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  state_t        state;
  logic [3:0]    bitcnt;
  logic [7:0]    shreg;
  logic          parity;
  logic [TW-1:0] to_cnt;
  logic          byte_valid, byte_err, to_err;
  logic          frame_ok;

  assign frame_ok = dat_s2 & (^shreg ^ parity);

  // The frame check runs on the stop-bit edge, so the verdict is already registered during S_DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      bitcnt     <= 4'd0;
      shreg      <= 8'd0;
      parity     <= 1'b0;
      to_cnt     <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      to_err     <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      to_err     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fall && !dat_s2) begin
            state  <= S_SHIFT;
            bitcnt <= 4'd1;
            to_cnt <= '0;
          end
        end
        S_SHIFT: begin
          if (fall) begin
            to_cnt <= '0;
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt <= 4'd8) begin
              shreg <= {dat_s2, shreg[7:1]};
            end else if (bitcnt == 4'd9) begin
              parity <= dat_s2;
            end else begin
              state      <= S_DONE;
              byte_valid <= frame_ok;
              byte_err   <= ~frame_ok;
            end
          end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
            state  <= S_IDLE;
            to_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  function automatic logic [OUTWIDTH-1:0] step(input logic [OUTWIDTH-1:0] cur,
                                               input logic sgn, input logic ovf,
                                               input logic [7:0] mag);
    logic signed [SW-1:0] d;
    logic signed [SW-1:0] s;
    d = ovf ? '0 : {{(SW-9){sgn}}, sgn, mag};
    d = d >>> SHIFT;
    s = $signed({{(SW-OUTWIDTH){1'b0}}, cur}) + d;
    if (s < MIN_S)      step = OUTWIDTH'(MINVAL);
    else if (s > MAX_S) step = OUTWIDTH'(MAXVAL);
    else                step = s[OUTWIDTH-1:0];
  endfunction

  logic [1:0]          idx;
  logic                f_l, f_r, f_xs, f_ys, f_xo, f_yo;
  logic [7:0]          dx_byte;
  logic                prev_l, prev_r;
  logic [OUTWIDTH-1:0] x_q, y_q, nx_x, nx_y;
  logic                lc_q, rc_q, lv_q, pv_q, fe_q;

  always_comb begin
    nx_x = step(x_q, f_xs, f_xo, dx_byte);
    nx_y = step(y_q, f_ys, f_yo, shreg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= 2'd0;
      {f_l, f_r, f_xs, f_ys, f_xo, f_yo} <= 6'd0;
      dx_byte <= 8'd0;
      prev_l  <= 1'b0;
      prev_r  <= 1'b0;
      x_q     <= OUTWIDTH'(INIT_X);
      y_q     <= OUTWIDTH'(INIT_Y);
      lc_q    <= 1'b0;
      rc_q    <= 1'b0;
      lv_q    <= 1'b0;
      pv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      lc_q <= 1'b0;
      rc_q <= 1'b0;
      pv_q <= 1'b0;
      fe_q <= byte_err | to_err;
      if (byte_err || to_err) begin
        idx <= 2'd0;
      end else if (byte_valid) begin
        case (idx)
          2'd0: begin
            // Bit 3 is always set in a header byte; anything else means we are out of step.
            if (shreg[3]) begin
              {f_yo, f_xo, f_ys, f_xs} <= shreg[7:4];
              f_r <= shreg[1];
              f_l <= shreg[0];
              idx <= 2'd1;
            end else begin
              fe_q <= 1'b1;
            end
          end
          2'd1: begin
            dx_byte <= shreg;
            idx     <= 2'd2;
          end
          default: begin
            idx    <= 2'd0;
            x_q    <= nx_x;
            y_q    <= nx_y;
            pv_q   <= 1'b1;
            lc_q   <= f_l & ~prev_l;
            rc_q   <= f_r & ~prev_r;
            lv_q   <= f_l;
            prev_l <= f_l;
            prev_r <= f_r;
          end
        endcase
      end
    end
  end

  assign bus.xcursor     = x_q;
  assign bus.ycursor     = y_q;
  assign bus.left_click  = lc_q;
  assign bus.right_click = rc_q;
  assign bus.left_level  = lv_q;
  assign bus.pkt_valid   = pv_q;
  assign bus.frame_err   = fe_q;
endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Directed bench for ps2_mouse_rx: bit-banged PS/2 frames, expected packet results queued,
// and a monitor that checks every pkt_valid and frame_err pulse against the queue.
module tb_ps2_mouse_rx;
  localparam int HALF = 16;
  localparam int TMO  = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_mouse_rx_if #(.OUTWIDTH(8)) bus();
  ps2_mouse_rx #(.TIMEOUT_CYC(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       lc;
    logic       rc;
    logic       lv;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   fe_seen  = 0;
  int   fe_exp   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = fr[i];
      wait_cyc(HALF);
      bus.ps2_clk = 1'b0;
      wait_cyc(HALF);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    send_bits(b, bad_par, 11);
    wait_cyc(2 * HALF);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] ex, input logic [7:0] ey,
                          input logic lc, input logic rc, input logic lv);
    exp_t e;
    e.x = ex; e.y = ey; e.lc = lc; e.rc = rc; e.lv = lv;
    exp_q.push_back(e);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
  endtask

  // Monitor: every output pulse is checked here, independent of the stimulus timing.
  initial begin
    logic last_fe;
    exp_t e;
    last_fe = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.frame_err === 1'b1) begin
        fe_seen++;
        check("frame_err_width", int'(last_fe), 0);
        check("frame_err_with_pkt", int'(bus.pkt_valid), 0);
      end
      last_fe = (bus.frame_err === 1'b1);
      if (bus.pkt_valid === 1'b1) begin
        check("pkt_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("xcursor", int'(bus.xcursor), int'(e.x));
          check("ycursor", int'(bus.ycursor), int'(e.y));
          check("left_click", int'(bus.left_click), int'(e.lc));
          check("right_click", int'(bus.right_click), int'(e.rc));
          check("left_level", int'(bus.left_level), int'(e.lv));
        end
      end else if ((bus.left_click | bus.right_click) === 1'b1) begin
        check("click_outside_pkt", int'(bus.left_click | bus.right_click), 0);
      end
    end
  end

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(2);
    check("reset_x", int'(bus.xcursor), 128);
    check("reset_y", int'(bus.ycursor), 128);
    check("reset_level", int'(bus.left_level), 0);
    check("reset_pkt_valid", int'(bus.pkt_valid), 0);

    send_pkt(8'h09, 8'h10, 8'h00, 8'd144, 8'd128, 1'b1, 1'b0, 1'b1);
    send_pkt(8'h18, 8'hF0, 8'h00, 8'd128, 8'd128, 1'b0, 1'b0, 1'b0);
    send_pkt(8'h18, 8'hF0, 8'h00, 8'd112, 8'd128, 1'b0, 1'b0, 1'b0);
    send_pkt(8'h08, 8'h00, 8'h40, 8'd112, 8'd192, 1'b0, 1'b0, 1'b0);
    send_pkt(8'h08, 8'h8A, 8'h00, 8'd250, 8'd192, 1'b0, 1'b0, 1'b0);
    send_pkt(8'h08, 8'h14, 8'h00, 8'd255, 8'd192, 1'b0, 1'b0, 1'b0);
    send_pkt(8'h18, 8'h00, 8'h00, 8'd0,   8'd192, 1'b0, 1'b0, 1'b0);
    send_pkt(8'h18, 8'h00, 8'h00, 8'd0,   8'd192, 1'b0, 1'b0, 1'b0);
    send_pkt(8'h48, 8'h7F, 8'h00, 8'd0,   8'd192, 1'b0, 1'b0, 1'b0);
    send_pkt(8'h0A, 8'h00, 8'h00, 8'd0,   8'd192, 1'b0, 1'b1, 1'b0);
    send_pkt(8'h29, 8'h05, 8'hFB, 8'd5,   8'd187, 1'b1, 1'b0, 1'b1);
    send_pkt(8'h09, 8'h00, 8'h00, 8'd5,   8'd187, 1'b0, 1'b0, 1'b1);

    // Parity error on the second byte drops the packet.
    send_byte(8'h08, 1'b0);
    send_byte(8'h10, 1'b1);
    fe_exp++;
    check("parity_err_count", fe_seen, fe_exp);
    send_pkt(8'h08, 8'h03, 8'h02, 8'd8, 8'd189, 1'b0, 1'b0, 1'b0);

    // Truncated frame, then the line idles past the timeout.
    send_bits(8'h55, 1'b0, 5);
    wait_cyc(TMO + 10);
    fe_exp++;
    check("timeout_err_count", fe_seen, fe_exp);
    send_pkt(8'h08, 8'h02, 8'h00, 8'd10, 8'd189, 1'b0, 1'b0, 1'b0);

    // 3-cycle clock glitch with data low would look like a start bit if it got through.
    bus.ps2_data = 1'b0;
    wait_cyc(1);
    bus.ps2_clk = 1'b0;
    wait_cyc(3);
    bus.ps2_clk = 1'b1;
    wait_cyc(1);
    bus.ps2_data = 1'b1;
    wait_cyc(40);
    check("glitch_no_err", fe_seen, fe_exp);
    send_pkt(8'h08, 8'h01, 8'h01, 8'd11, 8'd190, 1'b0, 1'b0, 1'b0);

    // Header without bit 3 is rejected.
    send_byte(8'h00, 1'b0);
    fe_exp++;
    check("sync_err_count", fe_seen, fe_exp);
    send_pkt(8'h09, 8'h04, 8'h00, 8'd15, 8'd190, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of a packet and a frame.
    send_byte(8'h09, 1'b0);
    send_bits(8'h01, 1'b0, 5);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);
    check("midrst_x", int'(bus.xcursor), 128);
    check("midrst_y", int'(bus.ycursor), 128);
    check("midrst_level", int'(bus.left_level), 0);
    send_pkt(8'h09, 8'h01, 8'h00, 8'd129, 8'd128, 1'b1, 1'b0, 1'b1);

    wait_cyc(50);
    check("queue_drained", exp_q.size(), 0);
    check("frame_err_total", fe_seen, fe_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
